// File: rtl/recirculacion_param.sv
// Two-stage registered recirculation stage: lanes are registered, then steered to
// the forward path or back to the probador under a debounced idle-sync mode FSM.
module recirculacion_param #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned IDLE_SYNC = 2,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                     clk_f,
    input  logic                     reset_L,
    input  logic                     idle_out,
    input  logic                     cnt_clr,
    input  logic [N_CH*DATA_W-1:0]   data_in,
    input  logic [N_CH-1:0]          valid_in,
    output logic [N_CH*DATA_W-1:0]   data_out,
    output logic [N_CH-1:0]          valid_out,
    output logic [N_CH*DATA_W-1:0]   data_rp,
    output logic [N_CH-1:0]          valid_rp,
    output logic [N_CH*CNT_W-1:0]    recirc_cnt,
    output logic                     fwd_mode
);

    localparam int unsigned IC_W = $clog2(IDLE_SYNC + 1);
    // idle_cnt value at which one more idle cycle completes the debounce
    localparam logic [IC_W-1:0] SYNC_LAST = IC_W'(IDLE_SYNC - 1);

    typedef enum logic [1:0] {
        RECIRC = 2'd0,
        ARM    = 2'd1,
        FWD    = 2'd2
    } state_t;

    state_t                 state;
    logic [IC_W-1:0]        idle_cnt;
    logic [N_CH*DATA_W-1:0] data_s;
    logic [N_CH-1:0]        valid_s;

    always_ff @(posedge clk_f) begin
        if (!reset_L) begin
            state    <= RECIRC;
            idle_cnt <= '0;
            fwd_mode <= 1'b0;
        end else begin
            case (state)
                RECIRC: begin
                    if (idle_out) begin
                        if (IDLE_SYNC == 1) begin
                            state    <= FWD;
                            fwd_mode <= 1'b1;
                        end else begin
                            state    <= ARM;
                            idle_cnt <= IC_W'(1);
                        end
                    end
                end
                ARM: begin
                    if (!idle_out) begin
                        state    <= RECIRC;
                        idle_cnt <= '0;
                    end else if (idle_cnt == SYNC_LAST) begin
                        state    <= FWD;
                        idle_cnt <= '0;
                        fwd_mode <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                FWD: begin
                    if (!idle_out) begin
                        state    <= RECIRC;
                        fwd_mode <= 1'b0;
                    end
                end
                default: begin
                    state    <= RECIRC;
                    idle_cnt <= '0;
                    fwd_mode <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_f) begin
        if (!reset_L) begin
            data_s  <= '0;
            valid_s <= '0;
        end else begin
            data_s  <= data_in;
            valid_s <= valid_in;
        end
    end

    // Routing uses the pre-edge fwd_mode, so a mode change hits the words already in stage 1
    always_ff @(posedge clk_f) begin
        if (!reset_L) begin
            data_out   <= '0;
            valid_out  <= '0;
            data_rp    <= '0;
            valid_rp   <= '0;
            recirc_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (fwd_mode) begin
                    valid_out[i]              <= valid_s[i];
                    data_out[i*DATA_W +: DATA_W] <= valid_s[i] ? data_s[i*DATA_W +: DATA_W] : '0;
                    valid_rp[i]               <= 1'b0;
                    data_rp[i*DATA_W +: DATA_W]  <= '0;
                end else begin
                    valid_rp[i]               <= valid_s[i];
                    data_rp[i*DATA_W +: DATA_W]  <= valid_s[i] ? data_s[i*DATA_W +: DATA_W] : '0;
                    valid_out[i]              <= 1'b0;
                    data_out[i*DATA_W +: DATA_W] <= '0;
                end

                if (cnt_clr) begin
                    recirc_cnt[i*CNT_W +: CNT_W] <= '0;
                end else if (!fwd_mode && valid_s[i] && (recirc_cnt[i*CNT_W +: CNT_W] != '1)) begin
                    recirc_cnt[i*CNT_W +: CNT_W] <= recirc_cnt[i*CNT_W +: CNT_W] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_recirculacion_param.sv
// Directed + random bench for recirculacion_param with a queue scoreboard of
// words captured in stage 1 and an idle run-length model of the mode.
module tb_recirculacion_param;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned IS = 2;
    localparam int unsigned CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic             clk_f = 1'b0;
    logic             reset_L = 1'b0;
    logic             idle_out = 1'b0;
    logic             cnt_clr = 1'b0;
    logic [N*W-1:0]   data_in = '0;
    logic [N-1:0]     valid_in = '0;
    logic [N*W-1:0]   data_out;
    logic [N-1:0]     valid_out;
    logic [N*W-1:0]   data_rp;
    logic [N-1:0]     valid_rp;
    logic [N*CW-1:0]  recirc_cnt;
    logic             fwd_mode;

    recirculacion_param #(
        .N_CH(N), .DATA_W(W), .IDLE_SYNC(IS), .CNT_W(CW)
    ) dut (
        .clk_f(clk_f), .reset_L(reset_L), .idle_out(idle_out), .cnt_clr(cnt_clr),
        .data_in(data_in), .valid_in(valid_in),
        .data_out(data_out), .valid_out(valid_out),
        .data_rp(data_rp), .valid_rp(valid_rp),
        .recirc_cnt(recirc_cnt), .fwd_mode(fwd_mode)
    );

    always #5 clk_f = ~clk_f;

    typedef struct {
        logic [N*W-1:0] d;
        logic [N-1:0]   v;
        bit             fwd;
    } rec_t;

    rec_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   run = 0;
    bit   exp_mode = 1'b0;
    int   exp_cnt[N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pk(input logic [7:0] b3, input logic [7:0] b2,
                                          input logic [7:0] b1, input logic [7:0] b0);
        return {b3, b2, b1, b0};
    endfunction

    // One clock: drive inputs, take the edge, then check every output against the scoreboard
    task automatic step(input bit rst_n, input bit idle, input bit clr,
                        input logic [N-1:0] v, input logic [N*W-1:0] d);
        rec_t            r;
        logic [N*W-1:0]  e_do, e_drp;
        logic [N-1:0]    e_vo, e_vrp;
        logic [N*CW-1:0] e_cnt;
        reset_L  = rst_n;
        idle_out = idle;
        cnt_clr  = clr;
        valid_in = v;
        data_in  = d;
        @(posedge clk_f);
        #1;
        e_do = '0; e_drp = '0; e_vo = '0; e_vrp = '0;
        if (!rst_n) begin
            run = 0;
            exp_mode = 1'b0;
            q.delete();
            q.push_back('{d: '0, v: '0, fwd: 1'b0});
            for (int i = 0; i < N; i++) exp_cnt[i] = 0;
        end else begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL scoreboard_empty: observed 0 entries expected 1");
                r = '{d: '0, v: '0, fwd: 1'b0};
            end else begin
                r = q.pop_front();
            end
            for (int i = 0; i < N; i++) begin
                if (r.v[i]) begin
                    if (r.fwd) begin
                        e_vo[i] = 1'b1;
                        e_do[i*W +: W] = r.d[i*W +: W];
                    end else begin
                        e_vrp[i] = 1'b1;
                        e_drp[i*W +: W] = r.d[i*W +: W];
                    end
                end
                if (clr) exp_cnt[i] = 0;
                else if (!r.fwd && r.v[i] && exp_cnt[i] < CMAX) exp_cnt[i]++;
            end
            run = idle ? run + 1 : 0;
            exp_mode = (run >= IS);
            q.push_back('{d: d, v: v, fwd: exp_mode});
        end
        for (int i = 0; i < N; i++) e_cnt[i*CW +: CW] = CW'(exp_cnt[i]);
        chk("data_out",   64'(data_out),   64'(e_do));
        chk("valid_out",  64'(valid_out),  64'(e_vo));
        chk("data_rp",    64'(data_rp),    64'(e_drp));
        chk("valid_rp",   64'(valid_rp),   64'(e_vrp));
        chk("recirc_cnt", 64'(recirc_cnt), 64'(e_cnt));
        chk("fwd_mode",   64'(fwd_mode),   64'(exp_mode));
    endtask

    initial begin
        // Reset with all-ones inputs
        step(0, 0, 0, '1, '1);
        step(0, 0, 0, '1, '1);
        chk("rst_outputs_zero", 64'({data_out, data_rp, valid_out, valid_rp}), 64'd0);
        step(1, 0, 0, '1, '1);
        chk("rst_release_no_rp_yet", 64'(valid_rp), 64'd0);
        step(1, 0, 0, '0, '0);
        chk("rst_release_rp_at_2", 64'(valid_rp), 64'hF);

        // Recirculate a single lane-0 word
        step(1, 0, 0, 4'b0001, pk(8'h00, 8'h00, 8'h00, 8'hA5));
        step(1, 0, 0, '0, '0);
        chk("recirc_a5_data", 64'(data_rp[7:0]), 64'hA5);
        chk("recirc_a5_out_idle", 64'(valid_out), 64'd0);

        // Debounce 1,0,1,1
        step(1, 1, 0, '0, '0);
        chk("debounce_first_1", 64'(fwd_mode), 64'd0);
        step(1, 0, 0, '0, '0);
        step(1, 1, 0, '0, '0);
        chk("debounce_after_one", 64'(fwd_mode), 64'd0);
        step(1, 1, 0, '0, '0);
        chk("debounce_fwd", 64'(fwd_mode), 64'd1);
        step(1, 1, 0, 4'b0001, pk(8'h00, 8'h00, 8'h00, 8'h3C));
        step(1, 1, 0, '0, '0);
        chk("fwd_3c_data", 64'(data_out[7:0]), 64'h3C);
        chk("fwd_3c_rp_zero", 64'(data_rp), 64'd0);

        // Exit FWD mid-burst: one idle_out=0 cycle during a 4-word all-lane burst
        step(1, 1, 0, '1, pk(8'h11, 8'h12, 8'h13, 8'h14));
        step(1, 0, 0, '1, pk(8'h21, 8'h22, 8'h23, 8'h24));
        chk("exit_fwd_next_edge", 64'(fwd_mode), 64'd0);
        step(1, 1, 0, '1, pk(8'h31, 8'h32, 8'h33, 8'h34));
        step(1, 1, 0, '1, pk(8'h41, 8'h42, 8'h43, 8'h44));
        step(1, 0, 0, '0, '0);
        step(1, 0, 0, '0, '0);

        // Saturate lane 2, then clear on an incrementing edge
        for (int i = 0; i < 20; i++)
            step(1, 0, 0, 4'b0100, pk(8'h00, 8'(i), 8'h00, 8'h00));
        step(1, 0, 0, '0, '0);
        chk("sat_lane2", 64'(recirc_cnt[2*CW +: CW]), 64'(CMAX));
        step(1, 0, 0, 4'b0100, pk(8'h00, 8'h77, 8'h00, 8'h00));
        step(1, 0, 1, '0, '0);
        chk("clr_beats_inc", 64'(recirc_cnt[2*CW +: CW]), 64'd0);

        // Reset during a forwarding burst, then a fresh debounce
        step(1, 1, 0, '1, pk(8'h51, 8'h52, 8'h53, 8'h54));
        step(1, 1, 0, '1, pk(8'h61, 8'h62, 8'h63, 8'h64));
        step(1, 1, 0, '1, pk(8'h71, 8'h72, 8'h73, 8'h74));
        step(0, 1, 0, '1, pk(8'h81, 8'h82, 8'h83, 8'h84));
        chk("midrst_mode", 64'(fwd_mode), 64'd0);
        step(1, 1, 0, '1, pk(8'h91, 8'h92, 8'h93, 8'h94));
        chk("midrst_rearm", 64'(fwd_mode), 64'd0);
        step(1, 1, 0, '1, pk(8'hA1, 8'hA2, 8'hA3, 8'hA4));
        step(1, 1, 0, '1, pk(8'hB1, 8'hB2, 8'hB3, 8'hB4));
        step(1, 1, 0, '0, '0);

        // Random sparse traffic
        for (int i = 0; i < 60; i++)
            step(1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                 4'($urandom_range(0, 15)), $urandom);
        step(1, 0, 0, '0, '0);
        step(1, 0, 0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
